map_vga_renderer: RTL and testbench
===================================

# map_vga_renderer

Display-side driver for the map modules. Generates the 640x480@60 VGA scan position `vga_h`/`vga_v` consumed by the active map, takes back the map's combinational ROM address, fetches the pixel from the shared background ROM, and emits pipeline-aligned RGB and sync. It sits between the active `mapN` instance, the block-ROM and the board's VGA pins.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz -> 25 MHz).
- `ROM_LAT`, 1: ROM read latency in system clocks; must be <= `CLK_DIV`-1.
- `ADDR_W`, 17: ROM address width.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: when low, RGB is forced to 0; timing keeps running.
- `vga_h` output 10: horizontal scan position, 0..799.
- `vga_v` output 10: vertical scan position, 0..524.
- `map_addr` input ADDR_W: address returned by the map for the current `vga_h`/`vga_v`.
- `rom_addr` output ADDR_W: registered address to the ROM.
- `rom_data` input 12: ROM pixel {R,G,B} 4 bits each.
- `hsync` output 1: active-low, aligned with `rgb`.
- `vsync` output 1: active-low, aligned with `rgb`.
- `rgb` output 12: pixel color.
- `pix_tick` output 1: one-clk strobe per pixel.
- `frame_start` output 1: one-clk pulse when `vga_v` wraps to 0.

## Operation
- Divider counts 0..CLK_DIV-1; `pix_tick`=1 on the clock where the count is CLK_DIV-1.
- Scan counters advance only on `pix_tick`: `vga_h` 0..799 wraps to 0 and increments `vga_v`; `vga_v` 0..524 wraps to 0.
- Active region: h<640 and v<480. Raw hsync low for h in 656..751; raw vsync low for v in 490..491.
- Pipeline, per pixel tick:
  - S0: counters, and `map_addr` is valid combinationally.
  - S1: `rom_addr` <= `map_addr`; active/hsync/vsync are delayed one stage.
  - S2: `rgb` <= (active_d1 && `en`) ? `rom_data` : 0; sync is delayed a second stage.
- Arithmetic: counters are unsigned 10-bit. Compares use full-width constants. There is no saturation, only explicit wrap.
- Simultaneous h wrap at 799 and v wrap at 524 take effect on the same tick. `frame_start` is asserted on that tick.
- `en` is sampled at S2; it gates color only and never sync.
- Reset, including mid-line: every register returns to its reset value immediately. The first `pix_tick` occurs CLK_DIV clocks after reset release. The scan restarts at (0,0).

## Timing
- Reset values:
  - `vga_h`=0, `vga_v`=0.
  - `rom_addr`=0.
  - `hsync`=1, `vsync`=1.
  - `rgb`=0.
  - `pix_tick`=0, `frame_start`=0.
  - Divider=0.
- Latency: scan position (h,v) appears on `rgb`/`hsync`/`vsync` exactly 2 pixel ticks after `vga_h`/`vga_v` show it.
- ROM contract: `rom_data` must be stable ROM_LAT clocks after `rom_addr` changes. It is sampled on the next `pix_tick`.
- All outputs are registered and change only on `clk` edges where `pix_tick`=1. `pix_tick` itself and the divider are the exception.

## Configuration
- `MAP_RENDER_GRID_EN` defined: in the active region, a gray grid (12'h888) overrides `rgb` when (h_d2[3:0]==0) or (v_d2[3:0]==0). This is a 16-VGA-pixel grid (8 map units) used for placing terrain pivots. Sync and latency are unchanged.
- Undefined: no grid logic is compiled. `rgb` is as described in Operation.

## Structure
- `render_pkg` holds:
  - The timing constants H_ACTIVE=640, H_FP=16, H_SYNC=96, H_BP=48, V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33.
  - The derived totals 800/525.
  - The blank color 12'h000 and the grid color 12'h888.
- Sub-module `vga_scan_timing`: the divider, the counters, raw sync/active and `frame_start`. The top level adds the address/data pipeline, sync delay and the grid option.

## Test plan
- Reset release: `pix_tick` first asserts 4 clocks later. `vga_h` steps 0->1 on that tick; `hsync`=`vsync`=1; `rgb`=0.
- Run to h=799, v=0: the next tick gives h=0, v=1. At v=524, h=799 the next tick gives (0,0) with `frame_start`=1 for exactly one clk.
- hsync alignment: raw hsync falls at h=656. The output `hsync` falls 2 ticks later and stays low for 96 ticks.
- Data path: drive `map_addr`=540 at (10,10) with a ROM model returning 12'hF00 for 540. `rom_addr`=540 after 1 tick; `rgb`=12'hF00 after 2 ticks.
- Blanking/`en`: at h=700, `rgb`=0 regardless of `rom_data`. In the active region with `en`=0, `rgb`=0 while sync still toggles.
- Mid-line reset at h=300, v=100: all outputs take their reset values asynchronously. After release the scan restarts at (0,0).

Source files
------------

// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module   : render_pkg
// Brief    : 640x480@60 VGA timing constants and colors for map_vga_renderer
// Revision : 1.0 - initial release
// ============================================================================
package render_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;

    localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync pulse windows, start inclusive and end exclusive
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [11:0] BLANK_COLOR = 12'h000;
    localparam logic [11:0] GRID_COLOR  = 12'h888;

endpackage
`default_nettype wire

// File: rtl/map_vga_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : map_vga_renderer_if
// Brief    : Scan position, ROM and VGA pin bundle of map_vga_renderer
// Revision : 1.0 - initial release
// ============================================================================
interface map_vga_renderer_if #(
    parameter int ADDR_W = 17
);
    logic [9:0]        vga_h;
    logic [9:0]        vga_v;
    logic [ADDR_W-1:0] map_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic              hsync;
    logic              vsync;
    logic [11:0]       rgb;
    logic              pix_tick;
    logic              frame_start;

    modport master (
        output vga_h, vga_v, rom_addr, hsync, vsync, rgb, pix_tick, frame_start,
        input  map_addr, rom_data
    );

    modport slave (
        input  vga_h, vga_v, rom_addr, hsync, vsync, rgb, pix_tick, frame_start,
        output map_addr, rom_data
    );
endinterface
`default_nettype wire

// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_timing
// Brief    : Pixel divider, 800x525 scan counters, raw sync/active, frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_timing
    import render_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [9:0]      o_vga_h,
    output logic [9:0]      o_vga_v,
    output logic            o_pix_tick,
    output logic            o_frame_start,
    output logic            o_active,
    output logic            o_hsync_n,
    output logic            o_vsync_n
);

    localparam int              DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic             w_pix_tick;
    logic             w_h_last;
    logic             w_v_last;

    assign w_pix_tick = (r_div == C_DIV_LAST);
    assign w_h_last   = (r_h == H_TOTAL - 10'd1);
    assign w_v_last   = (r_v == V_TOTAL - 10'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_pix_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (w_pix_tick) begin
            if (w_h_last) begin
                r_h <= 10'd0;
                r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    assign o_vga_h       = r_h;
    assign o_vga_v       = r_v;
    assign o_pix_tick    = w_pix_tick;
    // High on the tick whose edge wraps both counters back to (0,0)
    assign o_frame_start = w_pix_tick && w_h_last && w_v_last;
    assign o_active      = (r_h < H_ACTIVE) && (r_v < V_ACTIVE);
    assign o_hsync_n     = !((r_h >= H_SYNC_START) && (r_h < H_SYNC_END));
    assign o_vsync_n     = !((r_v >= V_SYNC_START) && (r_v < V_SYNC_END));

endmodule
`default_nettype wire

// File: rtl/map_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module   : map_vga_renderer
// Brief    : VGA scan driver: map address -> ROM -> aligned RGB/sync (2 ticks)
//            Define MAP_RENDER_GRID_EN to overlay a 16-pixel gray grid.
// Revision : 1.0 - initial release
// ============================================================================
module map_vga_renderer
    import render_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ROM_LAT = 1,
    parameter int ADDR_W  = 17
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           en,
    map_vga_renderer_if.master  bus
);

    // The ROM must settle before the sampling tick, one pixel period later
    if (ROM_LAT > CLK_DIV - 1) begin : g_rom_lat_check
        $error("map_vga_renderer: ROM_LAT must not exceed CLK_DIV-1");
    end

    logic [9:0]        w_h;
    logic [9:0]        w_v;
    logic              w_pix_tick;
    logic              w_frame_start;
    logic              w_active;
    logic              w_hsync_n;
    logic              w_vsync_n;

    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_active_d1;
    logic              r_hsync_d1;
    logic              r_vsync_d1;
    logic              r_hsync;
    logic              r_vsync;
    logic [11:0]       r_rgb;
    logic [11:0]       w_rgb_next;

    vga_scan_timing #(
        .CLK_DIV (CLK_DIV)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_vga_h       (w_h),
        .o_vga_v       (w_v),
        .o_pix_tick    (w_pix_tick),
        .o_frame_start (w_frame_start),
        .o_active      (w_active),
        .o_hsync_n     (w_hsync_n),
        .o_vsync_n     (w_vsync_n)
    );

`ifdef MAP_RENDER_GRID_EN
    logic [9:0] r_h_d1;
    logic [9:0] r_v_d1;
    logic       w_grid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_d1 <= 10'd0;
            r_v_d1 <= 10'd0;
        end else if (w_pix_tick) begin
            r_h_d1 <= w_h;
            r_v_d1 <= w_v;
        end
    end

    assign w_grid     = (r_h_d1[3:0] == 4'd0) || (r_v_d1[3:0] == 4'd0);
    assign w_rgb_next = (r_active_d1 && en) ? (w_grid ? GRID_COLOR : bus.rom_data)
                                            : BLANK_COLOR;
`else
    assign w_rgb_next = (r_active_d1 && en) ? bus.rom_data : BLANK_COLOR;
`endif

    // S1 captures address and flags, S2 captures color and the second sync stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr  <= '0;
            r_active_d1 <= 1'b0;
            r_hsync_d1  <= 1'b1;
            r_vsync_d1  <= 1'b1;
            r_hsync     <= 1'b1;
            r_vsync     <= 1'b1;
            r_rgb       <= BLANK_COLOR;
        end else if (w_pix_tick) begin
            r_rom_addr  <= bus.map_addr;
            r_active_d1 <= w_active;
            r_hsync_d1  <= w_hsync_n;
            r_vsync_d1  <= w_vsync_n;
            r_hsync     <= r_hsync_d1;
            r_vsync     <= r_vsync_d1;
            r_rgb       <= w_rgb_next;
        end
    end

    assign bus.vga_h       = w_h;
    assign bus.vga_v       = w_v;
    assign bus.pix_tick    = w_pix_tick;
    assign bus.frame_start = w_frame_start;
    assign bus.rom_addr    = r_rom_addr;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.rgb         = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_map_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_vga_renderer
// Brief    : Directed vector bench for map_vga_renderer (default build)
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_vga_renderer;

    localparam int ADDR_W = 17;

    typedef struct {
        int         h;
        int         v;
        logic       en;
        logic [11:0] rgb;
        logic       hsync;
        logic       vsync;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    map_vga_renderer_if #(.ADDR_W(ADDR_W)) bus ();

    map_vga_renderer #(
        .CLK_DIV (4),
        .ROM_LAT (1),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Map model: (10,10) is pinned to 540, elsewhere {v[6:0], h}
    assign bus.map_addr = (bus.vga_h == 10'd10 && bus.vga_v == 10'd10) ? 17'd540
                                                                      : {bus.vga_v[6:0], bus.vga_h};

    // One-clock ROM: 540 -> F00, otherwise addr[11:0] ^ A5A
    always @(posedge clk) begin
        if (bus.rom_addr == 17'd540) bus.rom_data <= 12'hF00;
        else                         bus.rom_data <= bus.rom_addr[11:0] ^ 12'hA5A;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step_pix();
        int k = 0;
        while (bus.pix_tick !== 1'b1) begin
            if (k == 16) begin
                n_cmp++;
                n_err++;
                $display("FAIL step_pix: pix_tick got 0 for 16 clocks, expected a strobe");
                return;
            end
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while (!(int'(bus.vga_h) == h && int'(bus.vga_v) == v)) begin
            if (n > 425000) begin
                n_cmp++;
                n_err++;
                $display("FAIL goto: position (%0d,%0d) not reached, expected (%0d,%0d)",
                         bus.vga_h, bus.vga_v, h, v);
                return;
            end
            step_pix();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t t, input int idx);
        en = t.en;
        goto(t.h, t.v);
        step_pix();
        step_pix();
        check($sformatf("vec%0d rgb", idx),   bus.rgb,   t.rgb);
        check($sformatf("vec%0d hsync", idx), bus.hsync, t.hsync);
        check($sformatf("vec%0d vsync", idx), bus.vsync, t.vsync);
    endtask

    initial begin
        vec_t vecs [12];
        int   nlow;

        vecs[0]  = '{h: 20,  v: 10,  en: 1'b1, rgb: 12'h24E, hsync: 1'b1, vsync: 1'b1};
        vecs[1]  = '{h: 639, v: 10,  en: 1'b1, rgb: 12'h025, hsync: 1'b1, vsync: 1'b1};
        vecs[2]  = '{h: 650, v: 10,  en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b1};
        vecs[3]  = '{h: 700, v: 10,  en: 1'b1, rgb: 12'h000, hsync: 1'b0, vsync: 1'b1};
        vecs[4]  = '{h: 100, v: 20,  en: 1'b0, rgb: 12'h000, hsync: 1'b1, vsync: 1'b1};
        vecs[5]  = '{h: 656, v: 20,  en: 1'b0, rgb: 12'h000, hsync: 1'b0, vsync: 1'b1};
        vecs[6]  = '{h: 5,   v: 479, en: 1'b1, rgb: 12'h65F, hsync: 1'b1, vsync: 1'b1};
        vecs[7]  = '{h: 5,   v: 480, en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b1};
        vecs[8]  = '{h: 100, v: 490, en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b0};
        vecs[9]  = '{h: 752, v: 491, en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b0};
        vecs[10] = '{h: 10,  v: 492, en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b1};
        vecs[11] = '{h: 30,  v: 493, en: 1'b1, rgb: 12'h000, hsync: 1'b1, vsync: 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst vga_h",       bus.vga_h,       0);
        check("rst vga_v",       bus.vga_v,       0);
        check("rst rom_addr",    bus.rom_addr,    0);
        check("rst hsync",       bus.hsync,       1);
        check("rst vsync",       bus.vsync,       1);
        check("rst rgb",         bus.rgb,         0);
        check("rst pix_tick",    bus.pix_tick,    0);
        check("rst frame_start", bus.frame_start, 0);

        // First tick CLK_DIV clocks after release
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel1 pix_tick", bus.pix_tick, 0);
        @(posedge clk); #1;
        check("rel2 pix_tick", bus.pix_tick, 0);
        @(posedge clk); #1;
        check("rel3 pix_tick", bus.pix_tick, 1);
        check("rel3 vga_h",    bus.vga_h,    0);
        @(posedge clk); #1;
        check("rel4 vga_h",    bus.vga_h,    1);
        check("rel4 hsync",    bus.hsync,    1);
        check("rel4 vsync",    bus.vsync,    1);
        check("rel4 rgb",      bus.rgb,      0);

        // hsync falls two ticks after raw, lasts 96 ticks
        goto(656, 0);
        check("hs at 656", bus.hsync, 1);
        step_pix();
        check("hs at 657", bus.hsync, 1);
        step_pix();
        check("hs at 658", bus.hsync, 0);
        nlow = 0;
        while (bus.hsync == 1'b0 && nlow < 200) begin
            nlow++;
            step_pix();
        end
        check("hs low ticks", nlow, 96);

        // Line wrap
        goto(799, 0);
        check("line end frame_start", bus.frame_start, 0);
        step_pix();
        check("line wrap vga_h", bus.vga_h, 0);
        check("line wrap vga_v", bus.vga_v, 1);

        // Data path at (10,10)
        goto(10, 10);
        step_pix();
        check("dp rom_addr", bus.rom_addr, 540);
        step_pix();
        check("dp rgb", bus.rgb, 12'hF00);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Asynchronous reset mid-line
        en = 1'b1;
        goto(300, 100);
        #3;
        rst = 1'b1;
        #1;
        check("mrst vga_h",    bus.vga_h,    0);
        check("mrst vga_v",    bus.vga_v,    0);
        check("mrst rom_addr", bus.rom_addr, 0);
        check("mrst rgb",      bus.rgb,      0);
        check("mrst hsync",    bus.hsync,    1);
        check("mrst vsync",    bus.vsync,    1);
        check("mrst pix_tick", bus.pix_tick, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mrst restart vga_h", bus.vga_h, 1);
        check("mrst restart vga_v", bus.vga_v, 0);

        for (int i = 6; i < 12; i++) run_vec(vecs[i], i);

        // Frame wrap with one-clock frame_start
        goto(799, 524);
        begin
            int k = 0;
            while (bus.pix_tick !== 1'b1 && k < 16) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("fw frame_start on tick", bus.frame_start, 1);
        @(posedge clk); #1;
        check("fw vga_h", bus.vga_h, 0);
        check("fw vga_v", bus.vga_v, 0);
        check("fw frame_start after", bus.frame_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
